// File: rtl/rpm_pkg.sv
//------------------------------------------------------------------------------
// Module : rpm_pkg
// Brief  : Shared types and width helpers for the response pool memory.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rpm_pkg;

    localparam int unsigned c_DATA_W = 64;
    localparam int unsigned c_RESP_W = 2;

    typedef struct packed {
        logic [c_DATA_W-1:0] data;
        logic [c_RESP_W-1:0] resp;
        logic                last;
    } beat_t;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rpm_free_fifo.sv
//------------------------------------------------------------------------------
// Module : rpm_free_fifo
// Brief  : Index FIFO of free pool entries, reset-filled with 0..DEPTH-1.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rpm_free_fifo
    import rpm_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [ptr_w(DEPTH)-1:0]     push_idx,
    input  logic                        pop,
    output logic [ptr_w(DEPTH)-1:0]     head_idx,
    output logic [cnt_w(DEPTH)-1:0]     count
);

    localparam int c_PTR_W = ptr_w(DEPTH);
    localparam int c_CNT_W = cnt_w(DEPTH);

    logic [c_PTR_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd;
    logic [c_PTR_W-1:0] r_wr;
    logic [c_CNT_W-1:0] r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= c_PTR_W'(i);
            end
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= c_CNT_W'(DEPTH);
        end else begin
            if (push) begin
                r_mem[r_wr] <= push_idx;
                r_wr        <= r_wr + c_PTR_W'(1);
            end
            if (pop) begin
                r_rd <= r_rd + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(push) - c_CNT_W'(pop);
        end
    end

    assign head_idx = r_mem[r_rd];
    assign count    = r_count;

endmodule

`default_nettype wire

// File: rtl/response_pool_memory.sv
//------------------------------------------------------------------------------
// Module : response_pool_memory
// Brief  : Shared R-beat pool with per-UID linked lists and free-index recycling.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module response_pool_memory
    import rpm_pkg::*;
#(
    parameter int NUM_UIDS    = 16,
    parameter int ID_WIDTH    = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int RESP_WIDTH  = 2,
    parameter int DEPTH       = 32,
    parameter int MAX_PER_UID = 16,
    parameter int STORE_FWD   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ID_WIDTH-1:0]          in_id,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [RESP_WIDTH-1:0]        in_resp,
    input  logic                         in_last,
    input  logic                         rel_req,
    input  logic [ID_WIDTH-1:0]          rel_uid,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ID_WIDTH-1:0]          out_id,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [RESP_WIDTH-1:0]        out_resp,
    output logic                         out_last,
    output logic                         free_ack,
    output logic [NUM_UIDS-1:0]          releasable,
    output logic [$clog2(DEPTH+1)-1:0]   free_count
);

    localparam int c_PTR_W = ptr_w(DEPTH);
    localparam int c_CNT_W = cnt_w(DEPTH);

    beat_t              r_mem  [DEPTH];
    logic [c_PTR_W-1:0] r_next [DEPTH];
    logic [c_PTR_W-1:0] r_head [NUM_UIDS];
    logic [c_PTR_W-1:0] r_tail [NUM_UIDS];
    logic [c_CNT_W-1:0] r_cnt  [NUM_UIDS];
    logic [c_CNT_W-1:0] r_done [NUM_UIDS];

    logic [c_PTR_W-1:0]  w_free_head;
    logic [c_CNT_W-1:0]  w_free_count;
    logic [NUM_UIDS-1:0] w_rel_ok;
    logic [c_PTR_W-1:0]  w_pop_idx;
    beat_t               w_head_beat;
    logic                w_in_ready;
    logic                w_acc;
    logic                w_pop;
    logic                w_same;

    rpm_free_fifo #(
        .DEPTH (DEPTH)
    ) u_free_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_pop),
        .push_idx (w_pop_idx),
        .pop      (w_acc),
        .head_idx (w_free_head),
        .count    (w_free_count)
    );

    always_comb begin
        w_rel_ok = '0;
        for (int u = 0; u < NUM_UIDS; u++) begin
            w_rel_ok[u] = (r_cnt[u] != '0) && ((STORE_FWD == 0) || (r_done[u] != '0));
        end
    end

    assign w_pop_idx   = r_head[rel_uid];
    assign w_head_beat = r_mem[w_pop_idx];
    assign w_in_ready  = (w_free_count != '0) && (r_cnt[in_id] != c_CNT_W'(MAX_PER_UID));
    assign w_acc       = in_valid & w_in_ready;
    assign w_pop       = out_valid & out_ready;
    assign w_same      = w_acc & w_pop & (in_id == rel_uid);

    // Beat storage needs no reset: a slot is only read once a list links it.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_mem[w_free_head] <= '{data: in_data, resp: in_resp, last: in_last};
            if (r_cnt[in_id] != '0) begin
                r_next[r_tail[in_id]] <= w_free_head;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int u = 0; u < NUM_UIDS; u++) begin
                r_head[u] <= '0;
                r_tail[u] <= '0;
                r_cnt[u]  <= '0;
                r_done[u] <= '0;
            end
        end else begin
            for (int u = 0; u < NUM_UIDS; u++) begin
                r_cnt[u]  <= r_cnt[u]
                           + c_CNT_W'(w_acc && (in_id == ID_WIDTH'(u)))
                           - c_CNT_W'(w_pop && (rel_uid == ID_WIDTH'(u)));
                r_done[u] <= r_done[u]
                           + c_CNT_W'(w_acc && in_last && (in_id == ID_WIDTH'(u)))
                           - c_CNT_W'(w_pop && w_head_beat.last && (rel_uid == ID_WIDTH'(u)));
            end
            if (w_pop) begin
                r_head[rel_uid] <= r_next[w_pop_idx];
            end
            // A write into a single-entry list being popped becomes the new head;
            // it overrides the stale next pointer read above.
            if (w_acc) begin
                r_tail[in_id] <= w_free_head;
                if ((r_cnt[in_id] == '0) || (w_same && (r_cnt[in_id] == c_CNT_W'(1)))) begin
                    r_head[in_id] <= w_free_head;
                end
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = rel_req & w_rel_ok[rel_uid];
    assign out_id     = rel_uid;
    assign out_data   = out_valid ? w_head_beat.data : '0;
    assign out_resp   = out_valid ? w_head_beat.resp : '0;
    assign out_last   = out_valid ? w_head_beat.last : 1'b0;
    assign free_ack   = out_valid;
    assign releasable = w_rel_ok;
    assign free_count = w_free_count;

endmodule

`default_nettype wire

// File: doc/response_pool_memory.md
Name: response_pool_memory

Overview:
Second-generation R-beat store between the fabric R channel and the R ordering unit. A single shared pool of DEPTH beat entries replaces fixed per-UID FIFOs. Beats are chained into per-UID linked lists, and free entries are recycled through a free-index FIFO. Adds an optional store-and-forward mode that releases a UID only once its whole burst (LAST) is stored, a per-UID quota, and a releasable-UID mask for the ordering unit.

Parameters:
NUM_UIDS, 16, number of unique IDs (lists)
ID_WIDTH, 4, UID width; must satisfy 2**ID_WIDTH >= NUM_UIDS
DATA_WIDTH, 64, R data width
RESP_WIDTH, 2, R resp width
DEPTH, 32, total shared beat entries (power of two, >= 2)
MAX_PER_UID, 16, per-UID beat quota (1..DEPTH)
STORE_FWD, 0, 1 = release a UID only when it holds >= 1 complete burst

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  fabric beat valid
in_ready  out  1  beat accepted when in_valid & in_ready
in_id  in  ID_WIDTH  beat UID
in_data  in  DATA_WIDTH  beat data
in_resp  in  RESP_WIDTH  beat resp
in_last  in  1  beat last
rel_req  in  1  release request
rel_uid  in  ID_WIDTH  UID to release from
out_valid  out  1  head beat of rel_uid presented
out_ready  in  1  downstream accepts; pop on out_valid & out_ready
out_id  out  ID_WIDTH  equals rel_uid
out_data  out  DATA_WIDTH  head data (0 when !out_valid)
out_resp  out  RESP_WIDTH  head resp (0 when !out_valid)
out_last  out  1  head last (0 when !out_valid)
free_ack  out  1  equals out_valid
releasable  out  NUM_UIDS  bit u = head of UID u is releasable
free_count  out  $clog2(DEPTH+1)  registered number of free entries

Behaviour:
- State: data/resp/last/next arrays [DEPTH]; per UID head, tail, cnt (CNT_W=$clog2(DEPTH+1)), done_cnt (completed bursts held); free FIFO of PTR_W=$clog2(DEPTH) indices with rd/wr pointers and free_count.
- Reset (rst high at posedge): free FIFO holds indices 0..DEPTH-1 in order; free_count=DEPTH; all cnt/done_cnt/head/tail=0. Outputs after reset: in_ready=1, out_valid=0, free_ack=0, releasable=0, out_* = 0. Reset mid-burst discards all stored beats. No partial state survives.
- Write: in_ready = (free_count!=0) & (cnt[in_id]!=MAX_PER_UID). No same-cycle bypass: a pop does not raise in_ready in the same cycle. On accept: entry = free FIFO head; write fields; if cnt==0, head=entry; otherwise next[tail]=entry. Then tail=entry, cnt+1, and done_cnt+1 if in_last.
- Release is combinational: rel_ok[u] = cnt[u]!=0 & (STORE_FWD==0 | done_cnt[u]!=0). releasable[u]=rel_ok[u]. out_valid = rel_req & rel_ok[rel_uid]. out_* read from head[rel_uid] with zero latency.
- Pop on out_valid & out_ready: head=next[head]; cnt-1; done_cnt-1 if the popped last=1; freed index is pushed to the free FIFO.
- Simultaneous accept and pop, different UIDs: both apply and free_count is unchanged.
- Simultaneous accept and pop, same UID:
  - cnt unchanged.
  - If cnt==1, the new head is the written entry; the tail update and head update must not conflict.
  - done_cnt nets both ±1.
- The same index is never both freed and allocated in one cycle, because allocation uses the pre-cycle free head.
- Data is in order within a UID. Across UIDs, order is decided only by rel_uid.
- out_ready while !out_valid: no effect. rel_uid change while out_valid & !out_ready: permitted, no state change.
- Widths: counters never wrap by construction. A pop is gated by cnt!=0 and an accept by quota and free space.

Decomposition:
- Package rpm_pkg: PTR_W, CNT_W derivations; beat_t struct {data, resp, last}.
- Sub-module rpm_free_fifo: DEPTH x PTR_W index FIFO with reset-init to 0..DEPTH-1, push/pop and count.
- Linked-list control and storage stay in the top.

Test Plan:
- Reset, then 4 beats UID 3 (data 0x10..0x13, last on 4th); release UID 3 with out_ready=1 -> 4 beats in order, out_last on 4th, free_count 32->28->32.
- Interleave UID 1 (0xA0,0xA1) with UID 2 (0xB0); release UID 2 then UID 1 -> 0xB0, then 0xA0, 0xA1; releasable[1] and [2] correct each cycle.
- Fill 32 beats across UIDs 0/5 with MAX_PER_UID=16 -> in_ready=0 at the 17th UID 0 beat while UID 5 is accepted. At free_count=0, in_ready=0 in the pop cycle and 1 the next cycle.
- STORE_FWD=1: 3 beats UID 7 without last -> releasable[7]=0, out_valid=0. Beat with last -> releasable[7]=1 and 4 beats drain.
- UID 4 holds 1 beat; same cycle pop 0x40 and write 0x41 -> next release yields 0x41, cnt stays 1.
- rst asserted mid-burst (10 beats stored) -> next cycle free_count=32, releasable=0, out_valid=0 for all rel_uid.
